// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its datapath core.
package shift_seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Encoding 2'b11 is reserved and behaves like MODE_LSR.
   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;

endpackage

// File: rtl/shift_reg_core.sv
// Shift register datapath: parallel load or one right shift per enabled edge.
module shift_reg_core
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             fill;

   always_comb begin
      case (mode)
         MODE_ASR: fill = q_q[WIDTH-1];
         MODE_ROR: fill = q_q[0];
         default:  fill = 1'b0;
      endcase
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = {fill, q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Load-then-shift sequencer: accepts a request in IDLE, runs N right shifts,
// pulses done for one cycle. abort returns to IDLE keeping the partial value.
//
// state | meaning
// IDLE  | waiting for start; q held
// SHIFT | one right shift per edge, count decrements to zero
// DONE  | single-cycle completion pulse; q held
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] load_val,
   input  logic [3:0]       shift_amt,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    mode_q, mode_d;
   logic [CW-1:0] amt_clamped;
   logic          load, shift;

   // Saturate the request at WIDTH so count can never wrap.
   always_comb begin
      if (32'(shift_amt) > 32'(WIDTH)) begin
         amt_clamped = CW'(WIDTH);
      end else begin
         amt_clamped = CW'(shift_amt);
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               load    = 1'b1;
               mode_d  = mode;
               count_d = amt_clamped;
               state_d = (amt_clamped == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               count_d = '0;
               state_d = IDLE;
            end else begin
               shift   = 1'b1;
               count_d = count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            count_d = '0;
            state_d = IDLE;
         end
         default: begin
            count_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         mode_q  <= MODE_LSR;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
      end
   end

   shift_reg_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .shift    (shift),
      .mode     (mode_q),
      .load_val (load_val),
      .q        (q)
   );

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expected values.
module tb_shift_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [7:0] load_val;
   logic [3:0] shift_amt;
   logic [1:0] mode;
   logic [7:0] q;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .load_val  (load_val),
      .shift_amt (shift_amt),
      .mode      (mode),
      .q         (q),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation; interfere drives start/load_val/mode during SHIFT.
   task automatic run_op(input string tag, input logic [7:0] lv, input logic [3:0] amt,
                         input logic [1:0] md, input int n, input logic [7:0] exp_q,
                         input bit interfere);
      load_val  = lv;
      shift_amt = amt;
      mode      = md;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " early done"}, 32'(done), 32'd0);
         if (interfere) begin
            start    = 1'b1;
            load_val = 8'h00;
            mode     = 2'b01;
         end
         tick();
      end
      start = 1'b0;
      chk({tag, " q"}, 32'(q), 32'(exp_q));
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy at done"}, 32'(busy), 32'd1);
      tick();
      chk({tag, " done cleared"}, 32'(done), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
      chk({tag, " q held"}, 32'(q), 32'(exp_q));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n   = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      load_val  = 8'h00;
      shift_amt = 4'd0;
      mode      = 2'b00;
      #2 reset_n = 1'b0;
      #1;
      chk("reset q", 32'(q), 32'h00);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      tick();
      tick();
      #3 reset_n = 1'b1;
      tick();

      run_op("lsr 96/3", 8'h96, 4'd3, 2'b00, 3, 8'h12, 1'b0);
      run_op("asr 80/7", 8'h80, 4'd7, 2'b01, 7, 8'hFF, 1'b0);
      run_op("ror 01/1", 8'h01, 4'd1, 2'b10, 1, 8'h80, 1'b0);
      run_op("ror 96/3", 8'h96, 4'd3, 2'b10, 3, 8'hD2, 1'b0);
      run_op("lsr 80/7", 8'h80, 4'd7, 2'b00, 7, 8'h01, 1'b0);
      run_op("rsvd 96/3", 8'h96, 4'd3, 2'b11, 3, 8'h12, 1'b0);
      run_op("amt0 5A", 8'h5A, 4'd0, 2'b00, 0, 8'h5A, 1'b0);
      run_op("clamp 80/12", 8'h80, 4'd12, 2'b01, 8, 8'hFF, 1'b0);
      run_op("clamp 96/15 lsr", 8'h96, 4'd15, 2'b00, 8, 8'h00, 1'b0);
      run_op("interfere F0/4", 8'hF0, 4'd4, 2'b00, 4, 8'h0F, 1'b1);
      mode = 2'b00;

      // Abort after two of four shifts.
      load_val  = 8'hF0;
      shift_amt = 4'd4;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abort q after 1", 32'(q), 32'h78);
      tick();
      chk("abort q after 2", 32'(q), 32'h3C);
      abort = 1'b1;
      tick();
      chk("abort q", 32'(q), 32'h3C);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      tick();
      chk("abort idle q", 32'(q), 32'h3C);
      chk("abort idle done", 32'(done), 32'd0);

      // abort beats start in IDLE.
      start    = 1'b1;
      load_val = 8'h55;
      tick();
      chk("abort+start busy", 32'(busy), 32'd0);
      chk("abort+start q", 32'(q), 32'h3C);
      start = 1'b0;
      abort = 1'b0;
      tick();

      run_op("after abort", 8'h01, 4'd1, 2'b10, 1, 8'h80, 1'b0);

      // Reset asserted between edges mid-operation.
      load_val  = 8'hF0;
      shift_amt = 4'd4;
      mode      = 2'b00;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("pre-reset q", 32'(q), 32'h78);
      #2 reset_n = 1'b0;
      #1;
      chk("midop reset q", 32'(q), 32'h00);
      chk("midop reset busy", 32'(busy), 32'd0);
      chk("midop reset done", 32'(done), 32'd0);
      tick();
      chk("held reset done", 32'(done), 32'd0);
      #3 reset_n = 1'b1;
      tick();
      chk("post reset done", 32'(done), 32'd0);

      run_op("post reset 96/3", 8'h96, 4'd3, 2'b00, 3, 8'h12, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the data width of the shift register.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a load-then-shift operation.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronously cancel an operation in progress.
REQ-006 The block SHALL have port load_val, input, WIDTH bits: value loaded at accept.
REQ-007 The block SHALL have port shift_amt, input, 4 bits: number of right shifts requested, 0..15.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 logical right (0 in at MSB), 01 arithmetic right (MSB replicated), 10 rotate right (LSB into MSB), 11 reserved and treated as 00.
REQ-009 The block SHALL have port q, output, WIDTH bits: current register contents.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted at the clock edge.
  - On that same edge: q <= load_val; count <= min(shift_amt, WIDTH); mode is captured.
  - The captured mode SHALL be held for the whole operation.
REQ-014 Accept transitions: if the clamped count is 0, next state = DONE; otherwise next state = SHIFT.
REQ-015 In SHIFT, each edge SHALL perform one right shift of q using the captured mode and decrement count.
  - When count==1 at the edge, next state = DONE.
REQ-016 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-017 Latency: with acceptance at edge E0 and clamped count N, q SHALL hold the final value after edge E_N and done SHALL be high during the cycle following E_N (N=0: the cycle after E0).
REQ-018 start SHALL be ignored in SHIFT and DONE; back-to-back throughput SHALL be one operation per N+2 cycles.
REQ-019 abort=1 in SHIFT or DONE SHALL force IDLE at the next edge.
  - q keeps its current partial value; done is not asserted; count is cleared.
  - abort has priority over start and over shifting.
REQ-020 abort=1 in IDLE SHALL have no effect; when start and abort are both 1 in IDLE, abort SHALL win and the request is not accepted.
REQ-021 q SHALL hold its value in IDLE and DONE.
REQ-022 shift_amt values greater than WIDTH SHALL saturate to WIDTH, so no wrap of count is possible.

Reset
REQ-023 reset_n=0 SHALL asynchronously set: state = IDLE, q = 0, count = 0, captured mode = 00, busy = 0, done = 0.
REQ-024 Reset asserted mid-operation SHALL discard the operation immediately with no done pulse.
REQ-025 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-026 A shared package shift_seq_pkg SHALL hold:
  - the state enumeration (IDLE, SHIFT, DONE);
  - the mode encodings (MODE_LSR, MODE_ASR, MODE_ROR);
  - the default WIDTH constant.
REQ-027 The datapath SHALL be one sub-module, shift_reg_core.
  - Ports: clk, reset_n, load, shift, mode, load_val, q.
  - It is driven by the FSM in shift_sequencer, which holds the state, count and captured mode.

Verification
REQ-028 Reset: pulse reset_n low between clock edges -> q=0x00, busy=0, done=0 immediately, without waiting for a clock edge.
REQ-029 Logical: load_val=0x96, shift_amt=3, mode=00 -> q=0x12 after E3, done pulse in the following cycle, busy high for 4 cycles.
REQ-030 Arithmetic and rotate:
  - load_val=0x80, shift_amt=7, mode=01 -> q=0xFF;
  - load_val=0x01, shift_amt=1, mode=10 -> q=0x80.
REQ-031 Boundaries:
  - shift_amt=0 with load_val=0x5A -> q=0x5A and done in the cycle after accept;
  - shift_amt=12, mode=01 with load_val=0x80 -> clamped to 8 -> q=0xFF.
REQ-032 Interference: start=1 with load_val=0x00 during SHIFT of a 0xF0, amt=4, mode=00 operation -> ignored, q=0x0F and done on schedule.
REQ-033 Cancellation:
  - abort after 2 of 4 shifts of 0xF0 -> q=0x3C, IDLE, no done;
  - reset_n low mid-operation -> q=0x00, no done.
